lut_mult_arbiter: RTL

- Shares one constant-coefficient LUT multiplier (lut_mult_8bit, coefficient A_CONST) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshake on every requester and on the result port.
- Two-stage pipeline around the combinational multiplier; each result carries the ID of its originating requester.
- Sits between the requesting datapath lanes and the multiplier, and is the only instantiator of the multiplier in the lane cluster.

---
 rtl/lut_mult_pkg.sv | 15 +
 rtl/lut_mult_8bit.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/lut_mult_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/lut_mult_pkg.sv
// Shared widths and helpers for the LUT multiplier arbiter cluster.
package lut_mult_pkg;

  localparam int BIT_WIDTH = 8;
  localparam int PROD_W    = 2 * BIT_WIDTH;
  localparam int MAX_REQ   = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/lut_mult_8bit.sv
// Combinational 8x8 constant-coefficient multiplier built from two 16-entry nibble tables.
module lut_mult_8bit #(
  parameter logic [7:0] A_CONST = 8'd2
) (
  input  logic [7:0]  x_i,
  output logic [15:0] c_o
);

  // 15 * 255 fits in 12 bits, so each nibble partial product is 12 wide.
  logic [11:0] nib_lut [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lut
      assign nib_lut[gi] = 12'(gi) * {4'b0, A_CONST};
    end
  endgenerate

  assign c_o = {4'b0, nib_lut[x_i[3:0]]} + {nib_lut[x_i[7:4]], 4'b0};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester after ptr_i (modulo N) wins while en_i is high.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic            en_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic [ID_W-1:0] cand [N];
  logic            found;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = ID_W'((int'(ptr_i) + gi + 1) % N);
    end
  endgenerate

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en_i && !found && req_i[cand[k]]) begin
        found           = 1'b1;
        gnt_o[cand[k]]  = 1'b1;
        idx_o           = cand[k];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/lut_mult_arbiter.sv
// Round-robin sharing of one LUT multiplier across NUM_REQ requesters, two-stage pipeline.
// Optional self-check of the multiplier output enabled by LUT_MULT_ARB_CHECK_EN.
module lut_mult_arbiter
  import lut_mult_pkg::*;
#(
  parameter logic [7:0] A_CONST   = 8'd2,
  parameter int         NUM_REQ   = 4,
  parameter int         BIT_WIDTH = 8,
  parameter int         ID_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_x,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [2*BIT_WIDTH-1:0]       res_c,
  output logic [ID_W-1:0]              res_id,
  output logic                         busy,
  output logic                         err
);

  logic                 s1_valid_q, s1_valid_d;
  logic [BIT_WIDTH-1:0] s1_x_q, s1_x_d;
  logic [ID_W-1:0]      s1_id_q, s1_id_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0]    s2_c_q, s2_c_d;
  logic [ID_W-1:0]      s2_id_q, s2_id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;

  logic                 s2_adv, s1_free, gnt_any;
  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_idx;
  logic [BIT_WIDTH-1:0] gnt_x;
  logic [PROD_W-1:0]    mult_c;
  logic [BIT_WIDTH-1:0] x_arr [NUM_REQ];

  assign s2_adv  = s1_valid_q & (~s2_valid_q | res_ready);
  assign s1_free = ~s1_valid_q | s2_adv;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_xsel
      assign x_arr[gi] = req_x[gi*BIT_WIDTH +: BIT_WIDTH];
    end
  endgenerate

  // Gating with rst keeps req_ready low for the whole reset window, not just after it.
  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i (req_valid),
    .en_i  (s1_free & ~rst),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready = gnt;
  assign gnt_x     = x_arr[gnt_idx];

  lut_mult_8bit #(.A_CONST(A_CONST)) u_mult (
    .x_i (s1_x_q),
    .c_o (mult_c)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_c_d     = s2_c_q;
    s2_id_d    = s2_id_q;
    ptr_d      = ptr_q;

    if (gnt_any) begin
      s1_valid_d = 1'b1;
      s1_x_d     = gnt_x;
      s1_id_d    = gnt_idx;
      ptr_d      = gnt_idx;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = 1'b1;
      s2_c_d     = mult_c;
      s2_id_d    = s1_id_q;
    end else if (res_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_id_q    <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_c_q     <= s2_c_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_c     = s2_c_q;
  assign res_id    = s2_id_q;
  assign busy      = s1_valid_q | s2_valid_q;

`ifdef LUT_MULT_ARB_CHECK_EN
  logic              err_q, err_d;
  logic [PROD_W-1:0] ref_c;

  assign ref_c = {{(PROD_W-BIT_WIDTH){1'b0}}, s1_x_q} * {{(PROD_W-8){1'b0}}, A_CONST};

  always_comb begin
    err_d = err_q;
    if (s2_adv && (mult_c != ref_c)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
